// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared states, opcodes, ALU operations and encodings for the multicycle control unit
package control_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_ERROR
    } state_t;

    typedef enum logic [2:0] {
        CL_R,
        CL_IARITH,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH
    } iclass_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IARITH = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - combinational opcode/funct classifier producing ALU operation and illegal flag
module alu_decode
    import control_pkg::*;
#(
    parameter int EN_IARITH = 1
) (
    input  logic [6:0] opcode,
    input  logic [3:0] funct,
    output iclass_t    iclass,
    output logic [3:0] op,
    output logic       illegal
);

    always_comb begin
        iclass  = CL_R;
        op      = ALU_ADD;
        illegal = 1'b0;
        case (opcode)
            OPC_R: begin
                iclass = CL_R;
                case (funct)
                    4'b0000: op = ALU_ADD;
                    4'b1000: op = ALU_SUB;
                    4'b0111: op = ALU_AND;
                    4'b0110: op = ALU_OR;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_IARITH: begin
                // funct[3] is an immediate bit for I-type, so only funct3 selects the op
                iclass  = CL_IARITH;
                illegal = (EN_IARITH == 0);
                case (funct[2:0])
                    3'b000:  op = ALU_ADD;
                    3'b111:  op = ALU_AND;
                    3'b110:  op = ALU_OR;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD:   iclass = CL_LOAD;
            OPC_STORE:  iclass = CL_STORE;
            OPC_BRANCH: begin
                iclass = CL_BRANCH;
                op     = ALU_SUB;
            end
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RISC-V control FSM with memory handshake, timeout and retire counter
module multicycle_control
    import control_pkg::*;
#(
    parameter int OP_W      = 4,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 15,
    parameter int EN_IARITH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       Opcode,
    input  logic [3:0]       Funct,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegWrite,
    output logic [OP_W-1:0]  Operation,
    output logic             busy,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state, nstate;
    iclass_t           cls_q, dec_cls;
    logic [3:0]        op_q, dec_op, alu_op;
    logic              dec_illegal;
    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting, timed_out, complete;
    logic [1:0]        err_q, err_d;

    // Zero only gates PCWriteCond inside the datapath; the sequencing never needs it
    logic unused_zero;
    assign unused_zero = Zero;

    alu_decode #(.EN_IARITH(EN_IARITH)) u_alu_decode (
        .opcode  (Opcode),
        .funct   (Funct),
        .iclass  (dec_cls),
        .op      (dec_op),
        .illegal (dec_illegal)
    );

    assign waiting   = (state == S_FETCH) || (state == S_MEM);
    assign timed_out = (TIMEOUT != 0) && waiting && !mem_ready && (wait_cnt == WAIT_LAST);

    always_comb begin
        nstate      = state;
        err_d       = err_q;
        complete    = 1'b0;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RS2;
        RegWrite    = 1'b0;
        alu_op      = ALU_ADD;
        case (state)
            S_IDLE: if (run) nstate = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    nstate  = S_DECODE;
                end else if (timed_out) begin
                    nstate = S_ERROR;
                    err_d  = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    nstate = S_ERROR;
                    err_d  = ERR_ILLEGAL;
                end else begin
                    nstate = S_EXEC;
                end
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                case (cls_q)
                    CL_R: begin
                        alu_op = op_q;
                        nstate = S_WB;
                    end
                    CL_IARITH: begin
                        ALUSrcB = SRCB_IMM;
                        alu_op  = op_q;
                        nstate  = S_WB;
                    end
                    CL_LOAD, CL_STORE: begin
                        ALUSrcB = SRCB_IMM;
                        nstate  = S_MEM;
                    end
                    default: begin
                        alu_op      = ALU_SUB;
                        PCWriteCond = 1'b1;
                        complete    = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                MemWrite = (cls_q == CL_STORE);
                MemRead  = (cls_q != CL_STORE);
                if (mem_ready) begin
                    if (cls_q == CL_STORE) complete = 1'b1;
                    else                   nstate   = S_WB;
                end else if (timed_out) begin
                    nstate = S_ERROR;
                    err_d  = ERR_TIMEOUT;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemtoReg = (cls_q == CL_LOAD);
                complete = 1'b1;
            end
            S_ERROR: ;
            default: nstate = S_IDLE;
        endcase
        if (complete) nstate = run ? S_FETCH : S_IDLE;
    end

    assign Operation = OP_W'(alu_op);
    assign busy      = (state != S_IDLE) && (state != S_ERROR);
    assign error     = (state == S_ERROR);
    assign err_code  = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cls_q    <= CL_R;
            op_q     <= ALU_ADD;
            wait_cnt <= '0;
            retired  <= '0;
            err_q    <= ERR_NONE;
        end else begin
            state <= nstate;
            err_q <= err_d;
            if (state == S_DECODE) begin
                cls_q <= dec_cls;
                op_q  <= dec_op;
            end
            if (complete) retired <= retired + CNT_W'(1);
            if (nstate != state)            wait_cnt <= '0;
            else if (waiting && !mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control against an instruction-level model
module tb_multicycle_control;

    localparam logic [6:0] OPC_R = 7'b0110011, OPC_IARITH = 7'b0010011, OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_BRANCH = 7'b1100011;
    localparam logic [3:0] OP_ADD = 4'b0010, OP_SUB = 4'b0110, OP_AND = 4'b0000, OP_OR = 4'b0001;
    localparam logic F = 1'b0, T = 1'b1;
    localparam logic [15:0] M_BASE = 16'hFC03, M_M2R = 16'h0200, M_ALU = 16'h01FC;
    localparam logic [15:0] M_IDLE = 16'hFE03, M_RST = 16'hFE3F;

    logic clk, rst_n, run, Zero, mem_ready;
    logic [6:0] Opcode;
    logic [3:0] Funct;
    logic [2:0] pcw, pcc, irw, mrd, mwr, m2r, sa, rw, bsy, err;
    logic [1:0] sb [3];
    logic [3:0] opr [3];
    logic [1:0] ec [3];
    logic [15:0] ret0, ret1;
    logic [1:0]  ret2;
    logic [15:0] obs_a, obs_c;

    int n_checks = 0;
    int n_fail = 0;
    int retired_model = 0;

    multicycle_control u_dut (
        .clk(clk), .rst_n(rst_n), .run(run), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .PCWrite(pcw[0]), .PCWriteCond(pcc[0]), .IRWrite(irw[0]),
        .MemRead(mrd[0]), .MemWrite(mwr[0]), .MemtoReg(m2r[0]), .ALUSrcA(sa[0]), .ALUSrcB(sb[0]),
        .RegWrite(rw[0]), .Operation(opr[0]), .busy(bsy[0]), .error(err[0]), .err_code(ec[0]),
        .retired(ret0));

    multicycle_control #(.EN_IARITH(0)) u_noi (
        .clk(clk), .rst_n(rst_n), .run(run), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .PCWrite(pcw[1]), .PCWriteCond(pcc[1]), .IRWrite(irw[1]),
        .MemRead(mrd[1]), .MemWrite(mwr[1]), .MemtoReg(m2r[1]), .ALUSrcA(sa[1]), .ALUSrcB(sb[1]),
        .RegWrite(rw[1]), .Operation(opr[1]), .busy(bsy[1]), .error(err[1]), .err_code(ec[1]),
        .retired(ret1));

    multicycle_control #(.CNT_W(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .run(run), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .PCWrite(pcw[2]), .PCWriteCond(pcc[2]), .IRWrite(irw[2]),
        .MemRead(mrd[2]), .MemWrite(mwr[2]), .MemtoReg(m2r[2]), .ALUSrcA(sa[2]), .ALUSrcB(sb[2]),
        .RegWrite(rw[2]), .Operation(opr[2]), .busy(bsy[2]), .error(err[2]), .err_code(ec[2]),
        .retired(ret2));

    assign obs_a = {pcw[0], pcc[0], irw[0], mrd[0], mwr[0], rw[0], m2r[0], sa[0], sb[0], opr[0], bsy[0], err[0]};
    assign obs_c = {pcw[2], pcc[2], irw[2], mrd[2], mwr[2], rw[2], m2r[2], sa[2], sb[2], opr[2], bsy[2], err[2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] v(input logic pcw_e, pcc_e, irw_e, mr_e, mw_e, rw_e, m2r_e, sa_e,
                                      input logic [1:0] sb_e, input logic [3:0] op_e, input logic busy_e, err_e);
        return {pcw_e, pcc_e, irw_e, mr_e, mw_e, rw_e, m2r_e, sa_e, sb_e, op_e, busy_e, err_e};
    endfunction

    // Spec-level decode table: ALU op for a legal instruction, -1 when illegal
    function automatic int ref_op(input logic [6:0] opc, input logic [3:0] fn, input bit en_i);
        if (opc == OPC_R) begin
            if (fn == 4'b0000) return 2;
            if (fn == 4'b1000) return 6;
            if (fn == 4'b0111) return 0;
            if (fn == 4'b0110) return 1;
            return -1;
        end
        if (opc == OPC_IARITH) begin
            if (!en_i) return -1;
            if (fn[2:0] == 3'b000) return 2;
            if (fn[2:0] == 3'b111) return 0;
            if (fn[2:0] == 3'b110) return 1;
            return -1;
        end
        if (opc == OPC_LOAD || opc == OPC_STORE) return 2;
        if (opc == OPC_BRANCH) return 6;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [15:0] exp, input logic [15:0] mask);
        n_checks++;
        assert (((obs_a & mask) === (exp & mask)) && ((obs_c & mask) === (exp & mask))) else begin
            n_fail++;
            $error("FAIL %s observed=%h/%h expected=%h", tag, obs_a & mask, obs_c & mask, exp & mask);
        end
    endtask

    task automatic chk_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic drive_mid(input int run_mid);
        if (run_mid == 2) run = 1'($urandom);
        else              run = run_mid[0];
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst_n = 1'b0; #1;
        chk("reset", v(F,F,F,F,F,F,F,F,2'b00,OP_ADD,F,F), M_RST);
        chk_val("reset_retired", 32'(ret0), 32'd0);
        chk_val("reset_err_code", 32'(ec[0]), 32'd0);
        @(negedge clk); rst_n = 1'b1; run = 1'b0;
        retired_model = 0;
    endtask

    task automatic leave_idle(input int idle_cycles);
        for (int i = 0; i < idle_cycles; i++) begin
            @(negedge clk); run = 1'b0; mem_ready = 1'($urandom); #1;
            chk("idle", v(F,F,F,F,F,F,F,F,2'b00,OP_ADD,F,F), M_IDLE);
        end
        @(negedge clk); run = 1'b1; #1;
        chk("idle_go", v(F,F,F,F,F,F,F,F,2'b00,OP_ADD,F,F), M_IDLE);
    endtask

    // Issues one instruction starting in FETCH and checks every cycle until it completes
    task automatic do_instr(input logic [6:0] opc, input logic [3:0] fn, input logic z,
                            input int fw, input int mw, input int run_mid, input logic run_end);
        int op;
        logic is_ld, is_st, is_br, is_imm;
        op     = ref_op(opc, fn, 1'b1);
        is_ld  = (opc == OPC_LOAD);
        is_st  = (opc == OPC_STORE);
        is_br  = (opc == OPC_BRANCH);
        is_imm = is_ld || is_st || (opc == OPC_IARITH);
        Opcode = opc;
        Funct  = fn;
        for (int i = 0; i < fw; i++) begin
            @(negedge clk); mem_ready = 1'b0; drive_mid(run_mid); #1;
            chk("fetch_wait", v(F,F,F,T,F,F,F,F,2'b01,OP_ADD,T,F), M_BASE | M_ALU);
        end
        @(negedge clk); mem_ready = 1'b1; drive_mid(run_mid); #1;
        chk("fetch", v(T,F,T,T,F,F,F,F,2'b01,OP_ADD,T,F), M_BASE | M_ALU);
        @(negedge clk); mem_ready = 1'($urandom); drive_mid(run_mid); #1;
        chk("decode", v(F,F,F,F,F,F,F,F,2'b00,OP_ADD,T,F), M_BASE);
        if (op < 0) begin
            @(negedge clk); #1;
            chk("illegal", v(F,F,F,F,F,F,F,F,2'b00,OP_ADD,F,T), M_IDLE);
            chk_val("illegal_err_code", 32'(ec[0]), 32'd1);
            return;
        end
        @(negedge clk); mem_ready = 1'($urandom); Zero = z;
        if (is_br) run = run_end; else drive_mid(run_mid);
        #1;
        chk("exec", v(F,is_br,F,F,F,F,F,T,is_imm ? 2'b10 : 2'b00,4'(op),T,F), M_BASE | M_ALU);
        if (is_ld || is_st) begin
            for (int i = 0; i < mw; i++) begin
                @(negedge clk); mem_ready = 1'b0; drive_mid(run_mid); #1;
                chk("mem_wait", v(F,F,F,is_ld,is_st,F,F,F,2'b00,OP_ADD,T,F), M_BASE);
            end
            @(negedge clk); mem_ready = 1'b1;
            if (is_st) run = run_end; else drive_mid(run_mid);
            #1;
            chk("mem", v(F,F,F,is_ld,is_st,F,F,F,2'b00,OP_ADD,T,F), M_BASE);
        end
        if (!is_br && !is_st) begin
            @(negedge clk); mem_ready = 1'($urandom); run = run_end; #1;
            chk("wb", v(F,F,F,F,F,T,is_ld,F,2'b00,OP_ADD,T,F), M_BASE | M_M2R);
        end
        retired_model++;
        @(posedge clk); #1;
        chk_val("retired", 32'(ret0), 32'(retired_model % 65536));
        chk_val("retired_wrap", 32'(ret2), 32'(retired_model % 4));
    endtask

    initial begin
        logic [3:0] rtab [4];
        logic [2:0] itab [3];
        rtab = '{4'b0000, 4'b1000, 4'b0111, 4'b0110};
        itab = '{3'b000, 3'b111, 3'b110};
        rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; Zero = 1'b0; Opcode = '0; Funct = '0;
        pulse_reset();

        leave_idle(2);
        do_instr(OPC_R, 4'b0000, F, 0, 0, 2, T);
        do_instr(OPC_R, 4'b1000, F, 0, 0, 2, T);
        do_instr(OPC_R, 4'b0111, T, 1, 0, 2, T);
        do_instr(OPC_R, 4'b0110, F, 0, 0, 2, T);
        do_instr(OPC_LOAD, 4'b0010, F, 0, 3, 2, T);
        do_instr(OPC_STORE, 4'b0010, F, 0, 2, 2, T);
        do_instr(OPC_BRANCH, 4'b0000, T, 0, 0, 2, F);
        leave_idle(3);
        do_instr(OPC_R, 4'b0000, F, 14, 0, 2, T);
        do_instr(OPC_LOAD, 4'b0000, F, 2, 14, 2, T);
        do_instr(OPC_IARITH, 4'b1000, F, 0, 0, 2, T);
        chk_val("noi_err_code", 32'(ec[1]), 32'd1);
        chk_val("noi_error", 32'(err[1]), 32'd1);
        chk_val("noi_retired", 32'(ret1), 32'(retired_model - 1));

        for (int k = 0; k < 40; k++) begin
            logic [6:0] opc;
            logic [3:0] fn;
            int fw, mw;
            logic re;
            fn = 4'($urandom);
            case ($urandom_range(0, 4))
                0: begin opc = OPC_R; fn = rtab[$urandom_range(0, 3)]; end
                1: begin opc = OPC_IARITH; fn[2:0] = itab[$urandom_range(0, 2)]; end
                2: opc = OPC_LOAD;
                3: opc = OPC_STORE;
                default: opc = OPC_BRANCH;
            endcase
            fw = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
            re = ($urandom_range(0, 3) != 0);
            do_instr(opc, fn, 1'($urandom), fw, mw, 2, re);
            if (!re) leave_idle(int'($urandom_range(0, 2)));
        end

        do_instr(OPC_R, 4'b1111, F, 0, 0, 2, T);
        pulse_reset();
        leave_idle(1);
        do_instr(7'b1101111, 4'b0000, F, 0, 0, 2, T);
        pulse_reset();

        leave_idle(0);
        Opcode = OPC_R; Funct = 4'b0000;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); mem_ready = 1'b0; run = 1'($urandom); #1;
            chk("timeout_wait", v(F,F,F,T,F,F,F,F,2'b01,OP_ADD,T,F), M_BASE | M_ALU);
        end
        @(negedge clk); #1;
        chk("timeout_error", v(F,F,F,F,F,F,F,F,2'b00,OP_ADD,F,T), M_IDLE);
        chk_val("timeout_err_code", 32'(ec[0]), 32'd2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); run = i[0]; mem_ready = 1'b1; #1;
            chk("error_sticky", v(F,F,F,F,F,F,F,F,2'b00,OP_ADD,F,T), M_IDLE);
        end
        chk_val("timeout_retired", 32'(ret0), 32'd0);
        pulse_reset();

        leave_idle(0);
        Opcode = OPC_STORE; Funct = 4'b0000;
        @(negedge clk); mem_ready = 1'b1; #1;
        chk("rst_fetch", v(T,F,T,T,F,F,F,F,2'b01,OP_ADD,T,F), M_BASE | M_ALU);
        @(negedge clk); #1;
        chk("rst_decode", v(F,F,F,F,F,F,F,F,2'b00,OP_ADD,T,F), M_BASE);
        @(negedge clk); #1;
        chk("rst_exec", v(F,F,F,F,F,F,F,T,2'b10,OP_ADD,T,F), M_BASE | M_ALU);
        @(negedge clk); mem_ready = 1'b0; #1;
        chk("rst_mem", v(F,F,F,F,T,F,F,F,2'b00,OP_ADD,T,F), M_BASE);
        #2 rst_n = 1'b0; #1;
        chk("rst_async", v(F,F,F,F,F,F,F,F,2'b00,OP_ADD,F,F), M_RST);
        @(negedge clk); #1;
        chk("rst_hold", v(F,F,F,F,F,F,F,F,2'b00,OP_ADD,F,F), M_RST);
        chk_val("rst_retired", 32'(ret0), 32'd0);
        rst_n = 1'b1; run = 1'b0; retired_model = 0;

        leave_idle(1);
        do_instr(OPC_LOAD, 4'b0000, F, 1, 2, 0, F);
        leave_idle(2);
        do_instr(OPC_R, 4'b0110, F, 0, 0, 0, F);
        @(negedge clk); run = 1'b0; #1;
        chk("run_drop_idle", v(F,F,F,F,F,F,F,F,2'b00,OP_ADD,F,F), M_IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
